axis_demux: RTL and testbench
=============================

# axis_demux

Packet-level AXI-Stream demultiplexer: one slave stream in, two master streams out, the counterpart of the two-to-one AXIS arbiter. The destination is taken from `s_axis_tdest` on the first beat of each packet and held until the beat carrying `tlast`, so packets are never split or interleaved. Each output has a one-deep register stage. The block sits between a shared stream source and two packet consumers.

## Interface
Parameters:
- `DATA_W`, default 8: tdata width in bits.

Ports:
- `aclk` input 1: single clock; all logic is rising-edge.
- `areset` input 1: asynchronous, active-high reset.
- `s_axis_tvalid` input 1: input beat valid.
- `s_axis_tready` output 1: input beat accepted.
- `s_axis_tdata` input DATA_W: input data.
- `s_axis_tlast` input 1: last beat of the packet.
- `s_axis_tdest` input 1: 0 routes the packet to output 1, 1 routes it to output 2. Sampled on the first beat only.
- `m_axis_tvalid1`, `m_axis_tvalid2` output 1: output beat valid.
- `m_axis_tready1`, `m_axis_tready2` input 1: downstream ready.
- `m_axis_tdata1`, `m_axis_tdata2` output DATA_W: output data.
- `m_axis_tlast1`, `m_axis_tlast2` output 1: output last beat.

## Operation
- A beat is accepted on an edge where `s_axis_tvalid && s_axis_tready`. A beat leaves output x on an edge where `m_axis_tvalidx && m_axis_treadyx`.
- Each output register slot x is free when `!m_axis_tvalidx || m_axis_treadyx`.
- FSM states:
  - IDLE: no packet open. `s_axis_tready` = the free flag of the output selected by the current `s_axis_tdest`.
    - Accepted beat with tlast=0 goes to ROUTE1 (tdest=0) or ROUTE2 (tdest=1).
    - Accepted beat with tlast=1 (single-beat packet) stays in IDLE.
  - ROUTEx: `s_axis_tready` = free flag of output x. `s_axis_tdest` is ignored. An accepted beat with tlast=1 returns to IDLE.
- Loading an output register: the accepted beat's tdata and tlast are captured into that output's register and its tvalid is set.
- Draining an output register: tvalid clears when the beat leaves and no new beat loads the same edge.
- The non-selected output keeps draining independently. Its contents never change while it is not selected.
- Output order within a packet equals input order. Packets to the same output are never reordered.

## Timing
- Reset values (asynchronous, while `areset`=1):
  - state = IDLE;
  - all `m_axis_tvalidx`, `m_axis_tlastx` = 0;
  - `m_axis_tdatax` = 0;
  - `s_axis_tready` = 0.
- Latency: a beat accepted at edge N is valid at the selected output from edge N until it is taken.
- Throughput: one beat per cycle when the selected `m_axis_treadyx` is held at 1.
- Back-to-back packets: the first beat of the next packet can be accepted on the edge after the tlast beat.
  - If the next packet goes to the other output, the previous tlast beat may still be pending there.
- Backpressure:
  - `m_axis_treadyx`=0 with output x full gives `s_axis_tready`=0.
  - Output data is held stable while `m_axis_tvalidx`=1 and `m_axis_treadyx`=0.
- Reset mid-packet: the open packet is truncated, buffered beats are discarded, and the block restarts in IDLE. There is no tlast recovery.
- `s_axis_tready` depends combinationally on `m_axis_treadyx`, the state and, in IDLE only, `s_axis_tdest`.

## Configuration
- Macro `AXIS_DEMUX_PKT_CNT_EN`.
- Defined: adds output ports `pkt_cnt1` and `pkt_cnt2`, each 16 bits.
  - Each counter increments on every tlast beat leaving its output.
  - It wraps from 0xFFFF to 0 and is reset to 0.
- Undefined: the ports and counters are absent. Datapath behaviour is identical in both cases.

## Structure
- Package `axis_demux_pkg`:
  - state enum `demux_state_t` {IDLE, ROUTE1, ROUTE2};
  - localparam `PKT_CNT_W`=16.
- Sub-module `axis_reg_slice`: a one-deep register with valid/ready, a load strobe and a free flag, parameterised by `DATA_W`. It is instantiated twice, once per output.

## Test plan
- Six-beat packet to output 1: tdest=0, data 0x24,0x81,0x09,0x63,0x0D,0x8D with tlast on the sixth beat, `m_axis_tready1`=1 → same six bytes on output 1 in order, tlast only on 0x8D, output 2 stays idle, one beat per cycle.
- Six-beat packet to output 2: tdest=1, tdest toggled to 0 mid-packet → all six beats appear on output 2 and none on output 1.
- Backpressure: `m_axis_tready1`=0 for 3 cycles mid-packet → `s_axis_tready`=0 during the stall, the held beat is stable, no beat is lost or duplicated after release.
- Alternating single-beat packets: 0xAA (tdest 0), 0x55 (tdest 1), 0xC3 (tdest 0), each with tlast=1 → each beat on its own output, state never leaves IDLE, one packet accepted per cycle.
- Reset mid-packet: `areset` asserted after beat 3 of 6 → all m tvalid and `s_axis_tready` drop immediately. After release, a new packet to output 2 routes correctly.
- With `AXIS_DEMUX_PKT_CNT_EN` defined: 3 packets to output 1 and 2 to output 2 → `pkt_cnt1`=3 and `pkt_cnt2`=2. Preloading near 0xFFFF via extra packets shows the counter wrap to 0.

Source files
------------

// File: rtl/axis_demux_pkg.sv
// Shared types and constants for the packet-level AXI-Stream demultiplexer.
package axis_demux_pkg;

    typedef enum logic [1:0] {IDLE, ROUTE1, ROUTE2} demux_state_t;

    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep output register with valid/ready handshake, load strobe and free flag.
module axis_reg_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              free,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    assign free = !valid || ready;

    // Load is only asserted while free, so it safely overrides the drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            last  <= in_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_demux.sv
// One-to-two AXI-Stream packet demultiplexer; destination latched on the first beat.
// Optional per-output packet counters are enabled with AXIS_DEMUX_PKT_CNT_EN.
module axis_demux
    import axis_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tdest,
    output logic              m_axis_tvalid1,
    input  logic              m_axis_tready1,
    output logic [DATA_W-1:0] m_axis_tdata1,
    output logic              m_axis_tlast1,
    output logic              m_axis_tvalid2,
    input  logic              m_axis_tready2,
    output logic [DATA_W-1:0] m_axis_tdata2,
`ifdef AXIS_DEMUX_PKT_CNT_EN
    output logic              m_axis_tlast2,
    output logic [PKT_CNT_W-1:0] pkt_cnt1,
    output logic [PKT_CNT_W-1:0] pkt_cnt2
`else
    output logic              m_axis_tlast2
`endif
);

    demux_state_t state;
    logic         free1;
    logic         free2;
    logic         sel2;
    logic         accept;

    // An open packet pins the destination; only IDLE follows the live tdest.
    always_comb begin
        sel2 = s_axis_tdest;
        if (state == ROUTE1) sel2 = 1'b0;
        if (state == ROUTE2) sel2 = 1'b1;
    end

    assign s_axis_tready = !areset && (sel2 ? free2 : free1);
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else if (accept) begin
            case (state)
                IDLE:    if (!s_axis_tlast) state <= s_axis_tdest ? ROUTE2 : ROUTE1;
                default: if (s_axis_tlast) state <= IDLE;
            endcase
        end
    end

    axis_reg_slice #(.DATA_W(DATA_W)) u_out1 (
        .clk     (aclk),
        .rst     (areset),
        .load    (accept && !sel2),
        .in_data (s_axis_tdata),
        .in_last (s_axis_tlast),
        .free    (free1),
        .valid   (m_axis_tvalid1),
        .ready   (m_axis_tready1),
        .data    (m_axis_tdata1),
        .last    (m_axis_tlast1)
    );

    axis_reg_slice #(.DATA_W(DATA_W)) u_out2 (
        .clk     (aclk),
        .rst     (areset),
        .load    (accept && sel2),
        .in_data (s_axis_tdata),
        .in_last (s_axis_tlast),
        .free    (free2),
        .valid   (m_axis_tvalid2),
        .ready   (m_axis_tready2),
        .data    (m_axis_tdata2),
        .last    (m_axis_tlast2)
    );

`ifdef AXIS_DEMUX_PKT_CNT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_cnt1 <= '0;
            pkt_cnt2 <= '0;
        end else begin
            if (m_axis_tvalid1 && m_axis_tready1 && m_axis_tlast1)
                pkt_cnt1 <= pkt_cnt1 + PKT_CNT_W'(1);
            if (m_axis_tvalid2 && m_axis_tready2 && m_axis_tlast2)
                pkt_cnt2 <= pkt_cnt2 + PKT_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_axis_demux.sv
// Directed self-checking bench for axis_demux (counter tests need AXIS_DEMUX_PKT_CNT_EN).
module tb_axis_demux;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tdest = 1'b0;
    logic       m_axis_tvalid1, m_axis_tvalid2;
    logic       m_axis_tready1 = 1'b1;
    logic       m_axis_tready2 = 1'b1;
    logic [7:0] m_axis_tdata1, m_axis_tdata2;
    logic       m_axis_tlast1, m_axis_tlast2;
`ifdef AXIS_DEMUX_PKT_CNT_EN
    logic [15:0] pkt_cnt1, pkt_cnt2;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int stalls = 0;
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    axis_demux #(.DATA_W(8)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tdest   (s_axis_tdest),
        .m_axis_tvalid1 (m_axis_tvalid1),
        .m_axis_tready1 (m_axis_tready1),
        .m_axis_tdata1  (m_axis_tdata1),
        .m_axis_tlast1  (m_axis_tlast1),
        .m_axis_tvalid2 (m_axis_tvalid2),
        .m_axis_tready2 (m_axis_tready2),
        .m_axis_tdata2  (m_axis_tdata2),
`ifdef AXIS_DEMUX_PKT_CNT_EN
        .m_axis_tlast2  (m_axis_tlast2),
        .pkt_cnt1       (pkt_cnt1),
        .pkt_cnt2       (pkt_cnt2)
`else
        .m_axis_tlast2  (m_axis_tlast2)
`endif
    );

    always #5 aclk = ~aclk;

    // Record every beat that leaves each output as {tlast, tdata}.
    always @(posedge aclk) begin
        if (!areset) begin
            if (m_axis_tvalid1 && m_axis_tready1) q1.push_back({m_axis_tlast1, m_axis_tdata1});
            if (m_axis_tvalid2 && m_axis_tready2) q2.push_back({m_axis_tlast2, m_axis_tdata2});
        end
    end

    // Called at a falling edge; returns at the falling edge after the beat is accepted.
    task automatic send_beat(input logic [7:0] d, input logic l, input logic dst);
        bit done = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tdest  = dst;
        for (int t = 0; t < 20 && !done; t++) begin
            #1;
            if (s_axis_tready) begin
                @(posedge aclk);
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(negedge aclk);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_beat: data %h never accepted, required acceptance within 20 cycles", d);
        end
    endtask

    task automatic drain();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_reset();
        s_axis_tvalid = 1'b1;
        #2;
        n_checks++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++; $display("FAIL reset_tready: got %b required 0", s_axis_tready);
        end
        n_checks++;
        if ({m_axis_tvalid1, m_axis_tvalid2, m_axis_tlast1, m_axis_tlast2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valid_last: got %b%b%b%b required 0000",
                     m_axis_tvalid1, m_axis_tvalid2, m_axis_tlast1, m_axis_tlast2);
        end
        n_checks++;
        if ({m_axis_tdata1, m_axis_tdata2} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got %h %h required 00 00", m_axis_tdata1, m_axis_tdata2);
        end
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_pkt_out1();
        logic [7:0] exp[6] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D};
        q1.delete(); q2.delete(); stalls = 0;
        for (int i = 0; i < 6; i++) send_beat(exp[i], i == 5, 1'b0);
        drain();
        n_checks++;
        if (stalls !== 0) begin n_fail++; $display("FAIL out1_rate: got %0d stalls required 0", stalls); end
        n_checks++;
        if (q1.size() !== 6) begin n_fail++; $display("FAIL out1_count: got %0d required 6", q1.size()); end
        for (int i = 0; i < 6 && i < q1.size(); i++) begin
            n_checks++;
            if (q1[i] !== {i == 5, exp[i]}) begin
                n_fail++; $display("FAIL out1_beat%0d: got %h required %h", i, q1[i], {i == 5, exp[i]});
            end
        end
        n_checks++;
        if (q2.size() !== 0) begin n_fail++; $display("FAIL out1_other_idle: got %0d required 0", q2.size()); end
    endtask

    task automatic test_pkt_out2();
        logic [7:0] exp[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic       dst[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        q1.delete(); q2.delete();
        for (int i = 0; i < 6; i++) send_beat(exp[i], i == 5, dst[i]);
        drain();
        n_checks++;
        if (q2.size() !== 6) begin n_fail++; $display("FAIL out2_count: got %0d required 6", q2.size()); end
        for (int i = 0; i < 6 && i < q2.size(); i++) begin
            n_checks++;
            if (q2[i] !== {i == 5, exp[i]}) begin
                n_fail++; $display("FAIL out2_beat%0d: got %h required %h", i, q2[i], {i == 5, exp[i]});
            end
        end
        n_checks++;
        if (q1.size() !== 0) begin n_fail++; $display("FAIL out2_other_idle: got %0d required 0", q1.size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        q1.delete(); q2.delete();
        for (int i = 0; i < 3; i++) send_beat(exp[i], 1'b0, 1'b0);
        m_axis_tready1 = 1'b0;
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = exp[3];
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (s_axis_tready !== 1'b0) begin
                n_fail++; $display("FAIL bp_tready_c%0d: got %b required 0", c, s_axis_tready);
            end
            n_checks++;
            if ({m_axis_tvalid1, m_axis_tdata1} !== {1'b1, exp[2]}) begin
                n_fail++;
                $display("FAIL bp_hold_c%0d: got %b/%h required 1/%h", c, m_axis_tvalid1, m_axis_tdata1, exp[2]);
            end
            @(negedge aclk);
        end
        m_axis_tready1 = 1'b1;
        for (int i = 3; i < 6; i++) send_beat(exp[i], i == 5, 1'b0);
        drain();
        n_checks++;
        if (q1.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d required 6", q1.size()); end
        for (int i = 0; i < 6 && i < q1.size(); i++) begin
            n_checks++;
            if (q1[i] !== {i == 5, exp[i]}) begin
                n_fail++; $display("FAIL bp_beat%0d: got %h required %h", i, q1[i], {i == 5, exp[i]});
            end
        end
    endtask

    task automatic test_back_to_back_single();
        q1.delete(); q2.delete(); stalls = 0;
        send_beat(8'hAA, 1'b1, 1'b0);
        send_beat(8'h55, 1'b1, 1'b1);
        send_beat(8'hC3, 1'b1, 1'b0);
        drain();
        n_checks++;
        if (stalls !== 0) begin n_fail++; $display("FAIL single_rate: got %0d stalls required 0", stalls); end
        n_checks++;
        if (q1.size() !== 2 || q1[0] !== 9'h1AA || q1[1] !== 9'h1C3) begin
            n_fail++; $display("FAIL single_out1: got %0d beats %p required 1aa,1c3", q1.size(), q1);
        end
        n_checks++;
        if (q2.size() !== 1 || q2[0] !== 9'h155) begin
            n_fail++; $display("FAIL single_out2: got %0d beats %p required 155", q2.size(), q2);
        end
    endtask

    task automatic test_reset_mid_packet();
        q1.delete(); q2.delete();
        send_beat(8'hB0, 1'b0, 1'b0);
        send_beat(8'hB1, 1'b0, 1'b0);
        send_beat(8'hB2, 1'b0, 1'b0);
        s_axis_tdata = 8'hB3;
        areset = 1'b1;
        #1;
        n_checks++;
        if ({m_axis_tvalid1, m_axis_tvalid2, s_axis_tready} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_drop: got %b%b%b required 000", m_axis_tvalid1, m_axis_tvalid2, s_axis_tready);
        end
        n_checks++;
        if (m_axis_tdata1 !== 8'h00) begin
            n_fail++; $display("FAIL midrst_data: got %h required 00", m_axis_tdata1);
        end
        @(negedge aclk);
        areset = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        send_beat(8'hC0, 1'b0, 1'b1);
        send_beat(8'hC1, 1'b0, 1'b0);
        send_beat(8'hC2, 1'b1, 1'b0);
        drain();
        n_checks++;
        if (q1.size() !== 2) begin n_fail++; $display("FAIL midrst_out1: got %0d beats required 2", q1.size()); end
        n_checks++;
        if (q2.size() !== 3 || q2[0] !== 9'h0C0 || q2[1] !== 9'h0C1 || q2[2] !== 9'h1C2) begin
            n_fail++; $display("FAIL midrst_out2: got %0d beats %p required 0c0,0c1,1c2", q2.size(), q2);
        end
    endtask

`ifdef AXIS_DEMUX_PKT_CNT_EN
    task automatic test_pkt_cnt();
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        for (int p = 0; p < 3; p++) begin
            send_beat(8'h10, 1'b0, 1'b0);
            send_beat(8'h11, 1'b1, 1'b0);
        end
        send_beat(8'h20, 1'b1, 1'b1);
        send_beat(8'h21, 1'b1, 1'b1);
        drain();
        n_checks++;
        if (pkt_cnt1 !== 16'd3) begin n_fail++; $display("FAIL cnt1: got %0d required 3", pkt_cnt1); end
        n_checks++;
        if (pkt_cnt2 !== 16'd2) begin n_fail++; $display("FAIL cnt2: got %0d required 2", pkt_cnt2); end
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        s_axis_tdest  = 1'b0;
        repeat (65532) @(negedge aclk);
        drain();
        n_checks++;
        if (pkt_cnt1 !== 16'hFFFF) begin n_fail++; $display("FAIL cnt1_max: got %h required ffff", pkt_cnt1); end
        send_beat(8'h30, 1'b1, 1'b0);
        drain();
        n_checks++;
        if (pkt_cnt1 !== 16'h0000) begin n_fail++; $display("FAIL cnt1_wrap: got %h required 0000", pkt_cnt1); end
        n_checks++;
        if (pkt_cnt2 !== 16'd2) begin n_fail++; $display("FAIL cnt2_hold: got %0d required 2", pkt_cnt2); end
    endtask
`endif

    initial begin
        test_reset();
        test_pkt_out1();
        test_pkt_out2();
        test_backpressure();
        test_back_to_back_single();
        test_reset_mid_packet();
`ifdef AXIS_DEMUX_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
